pipelined_decode: RTL and testbench

RV32I decode stage with a registered output and a valid/ready handshake on both sides. It sits between fetch and execute.
- Decodes all nine base opcode classes (R, I, LOAD, STORE, BRANCH, JAL, JALR, AUIPC, LUI) into execute controls.
- Computes the JAL target locally.
- Stalls on load-use hazards using an in-flight load scoreboard.
- Kills wrong-path work on flush.

---
 rtl/decode_pkg.sv | 43 ++++
 rtl/decode_ctrl.sv | 98 +++++++++
 rtl/pipelined_decode.sv | 160 ++++++++++++++++
 tb/tb_pipelined_decode.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/decode_pkg.sv
// Shared opcode, ALU and operand-select encodings for the RV32I decode stage,
// plus the packed control word passed from decode_ctrl to the output register.
package decode_pkg;

  localparam logic [6:0] R_TYPE = 7'b0110011;
  localparam logic [6:0] I_TYPE = 7'b0010011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] AUIPC  = 7'b0010111;
  localparam logic [6:0] LUI    = 7'b0110111;

  localparam logic [5:0] ALU_ADD = 6'b000000;
  localparam logic [5:0] ALU_SUB = 6'b010000;
  localparam logic [5:0] ALU_BR  = 6'b100000;

  localparam logic [1:0] OPA_RS1  = 2'b00;
  localparam logic [1:0] OPA_PC   = 2'b01;
  localparam logic [1:0] OPA_ZERO = 2'b10;

  typedef struct packed {
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        wen;
    logic        mem_wen;
    logic        wb_sel;
    logic [1:0]  opa;
    logic        opb;
    logic [5:0]  alu;
    logic [31:0] imm;
    logic        br;
    logic        jal;
    logic        jalr;
    logic        ill;
    logic        is_load;
  } ctrl_t;

  localparam int CTRL_W = $bits(ctrl_t);

endpackage

// File: rtl/decode_ctrl.sv
// Purely combinational RV32I instruction-to-control mapping, including the
// JAL target (PC + J-immediate, truncated to ADDRESS_BITS).
module decode_ctrl
  import decode_pkg::*;
#(
  parameter int ADDRESS_BITS = 16
) (
  input  logic [31:0]             instr_i,
  input  logic [ADDRESS_BITS-1:0] pc_i,
  output logic [CTRL_W-1:0]       ctrl_o,
  output logic                    use_rs1_o,
  output logic                    use_rs2_o,
  output logic [ADDRESS_BITS-1:0] jal_target_o
);

  ctrl_t              c;
  logic [2:0]         f3;
  logic signed [20:0] jimm;

  assign f3   = instr_i[14:12];
  assign jimm = {instr_i[31], instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};
  assign jal_target_o = pc_i + ADDRESS_BITS'(jimm);
  assign ctrl_o = c;

  always_comb begin
    c         = '0;
    use_rs1_o = 1'b0;
    use_rs2_o = 1'b0;
    c.rs1     = instr_i[19:15];
    c.rs2     = instr_i[24:20];
    c.rd      = instr_i[11:7];
    c.alu     = ALU_ADD;
    c.opa     = OPA_RS1;
    unique case (instr_i[6:0])
      R_TYPE: begin
        c.alu = {1'b0, instr_i[30], 1'b0, f3};
        c.opb = 1'b1;
        c.wen = 1'b1;
        use_rs1_o = 1'b1;
        use_rs2_o = 1'b1;
      end
      I_TYPE: begin
        // funct7[5] only selects SRAI vs SRLI; elsewhere it is immediate data
        c.alu = (f3 == 3'b101) ? {1'b0, instr_i[30], 1'b0, f3} : {3'b000, f3};
        c.imm = {{20{instr_i[31]}}, instr_i[31:20]};
        c.wen = 1'b1;
        use_rs1_o = 1'b1;
      end
      LOAD: begin
        c.imm     = {{20{instr_i[31]}}, instr_i[31:20]};
        c.wen     = 1'b1;
        c.wb_sel  = 1'b1;
        c.is_load = 1'b1;
        use_rs1_o = 1'b1;
      end
      STORE: begin
        c.imm     = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
        c.mem_wen = 1'b1;
        use_rs1_o = 1'b1;
        use_rs2_o = 1'b1;
      end
      BRANCH: begin
        c.alu = ALU_BR | {3'b000, f3};
        c.imm = {{20{instr_i[31]}}, instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
        c.opb = 1'b1;
        c.br  = 1'b1;
        use_rs1_o = 1'b1;
        use_rs2_o = 1'b1;
      end
      JAL: begin
        c.imm = 32'd4;
        c.opa = OPA_PC;
        c.jal = 1'b1;
        c.wen = 1'b1;
      end
      JALR: begin
        c.imm  = 32'd4;
        c.opa  = OPA_PC;
        c.jalr = 1'b1;
        c.wen  = 1'b1;
        use_rs1_o = 1'b1;
      end
      AUIPC: begin
        c.imm = {instr_i[31:12], 12'h000};
        c.opa = OPA_PC;
        c.wen = 1'b1;
      end
      LUI: begin
        c.imm = {instr_i[31:12], 12'h000};
        c.opa = OPA_ZERO;
        c.wen = 1'b1;
      end
      default: c.ill = 1'b1;
    endcase
    if (c.rd == 5'd0) c.wen = 1'b0;
  end

endmodule

// File: rtl/pipelined_decode.sv
// RV32I decode stage: registered output, valid/ready on both sides, load-use
// scoreboard and flush. Define DECODE_PERF_CNT_EN to add stall/issue counters.
module pipelined_decode
  import decode_pkg::*;
#(
  parameter int ADDRESS_BITS = 16,
  parameter int LOAD_LAT     = 2
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [ADDRESS_BITS-1:0] in_PC,
  input  logic [31:0]             in_instr,
  input  logic                    flush,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [ADDRESS_BITS-1:0] out_PC,
  output logic [4:0]              read_sel1,
  output logic [4:0]              read_sel2,
  output logic [4:0]              write_sel,
  output logic                    wEn,
  output logic                    mem_wEn,
  output logic                    wb_sel,
  output logic [1:0]              op_A_sel,
  output logic                    op_B_sel,
  output logic [5:0]              ALU_Control,
  output logic [31:0]             imm32,
  output logic                    branch_op,
  output logic                    jal_op,
  output logic                    jalr_op,
  output logic [ADDRESS_BITS-1:0] jal_target,
  output logic                    illegal
`ifdef DECODE_PERF_CNT_EN
  ,
  output logic [31:0]             stall_cycles,
  output logic [31:0]             issued_count
`endif
);

  logic [CTRL_W-1:0]       dec_bits;
  ctrl_t                   dec;
  logic                    use_rs1, use_rs2;
  logic [ADDRESS_BITS-1:0] dec_tgt;

  decode_ctrl #(.ADDRESS_BITS(ADDRESS_BITS)) u_ctrl (
    .instr_i      (in_instr),
    .pc_i         (in_PC),
    .ctrl_o       (dec_bits),
    .use_rs1_o    (use_rs1),
    .use_rs2_o    (use_rs2),
    .jal_target_o (dec_tgt)
  );

  assign dec = ctrl_t'(dec_bits);

  ctrl_t                         out_q, out_d;
  logic                          out_valid_q, out_valid_d;
  logic [ADDRESS_BITS-1:0]       pc_q, pc_d, tgt_q, tgt_d;
  logic [LOAD_LAT-1:0]           sb_v_q, sb_v_d;
  logic [LOAD_LAT-1:0][4:0]      sb_rd_q, sb_rd_d;
  logic                          hit1, hit2, hazard, accept, issue;

  // A load still in the output register counts as busy, as does any scoreboard entry
  always_comb begin
    hit1 = out_valid_q && out_q.is_load && (out_q.rd == dec.rs1);
    hit2 = out_valid_q && out_q.is_load && (out_q.rd == dec.rs2);
    for (int i = 0; i < LOAD_LAT; i++) begin
      hit1 = hit1 || (sb_v_q[i] && (sb_rd_q[i] == dec.rs1));
      hit2 = hit2 || (sb_v_q[i] && (sb_rd_q[i] == dec.rs2));
    end
    hazard = in_valid && ((use_rs1 && (dec.rs1 != 5'd0) && hit1) ||
                          (use_rs2 && (dec.rs2 != 5'd0) && hit2));
  end

  assign in_ready = reset && (flush || ((!out_valid_q || out_ready) && !hazard));
  assign accept   = in_valid && in_ready;
  assign issue    = out_valid_q && out_ready;

  always_comb begin
    out_valid_d = out_valid_q;
    out_d       = out_q;
    pc_d        = pc_q;
    tgt_d       = tgt_q;
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (accept) begin
      out_valid_d = 1'b1;
      out_d       = dec;
      pc_d        = in_PC;
      tgt_d       = dec_tgt;
    end else if (issue) begin
      out_valid_d = 1'b0;
    end

    // Flush does not clear in-flight loads; they are older than the redirect
    sb_v_d     = '0;
    sb_rd_d    = '0;
    sb_v_d[0]  = issue && out_q.is_load && (out_q.rd != 5'd0);
    sb_rd_d[0] = sb_v_d[0] ? out_q.rd : 5'd0;
    for (int i = 1; i < LOAD_LAT; i++) begin
      sb_v_d[i]  = sb_v_q[i-1];
      sb_rd_d[i] = sb_rd_q[i-1];
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      out_valid_q <= 1'b0;
      out_q       <= '0;
      pc_q        <= '0;
      tgt_q       <= '0;
      sb_v_q      <= '0;
      sb_rd_q     <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_q       <= out_d;
      pc_q        <= pc_d;
      tgt_q       <= tgt_d;
      sb_v_q      <= sb_v_d;
      sb_rd_q     <= sb_rd_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_PC      = pc_q;
  assign read_sel1   = out_q.rs1;
  assign read_sel2   = out_q.rs2;
  assign write_sel   = out_q.rd;
  assign wEn         = out_q.wen;
  assign mem_wEn     = out_q.mem_wen;
  assign wb_sel      = out_q.wb_sel;
  assign op_A_sel    = out_q.opa;
  assign op_B_sel    = out_q.opb;
  assign ALU_Control = out_q.alu;
  assign imm32       = out_q.imm;
  assign branch_op   = out_q.br;
  assign jal_op      = out_q.jal;
  assign jalr_op     = out_q.jalr;
  assign jal_target  = tgt_q;
  assign illegal     = out_q.ill;

`ifdef DECODE_PERF_CNT_EN
  logic [31:0] stall_q, issued_q;

  always_ff @(posedge clock) begin
    if (!reset) begin
      stall_q  <= '0;
      issued_q <= '0;
    end else begin
      if (in_valid && hazard && !flush) stall_q <= stall_q + 32'd1;
      if (issue) issued_q <= issued_q + 32'd1;
    end
  end

  assign stall_cycles = stall_q;
  assign issued_count = issued_q;
`endif

endmodule

// File: tb/tb_pipelined_decode.sv
// Directed plus randomized bench for pipelined_decode against a behavioural
// model (per-register busy-until times instead of a shift register).
module tb_pipelined_decode;

  localparam int AB = 16;
  localparam int LL = 2;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          in_valid = 1'b0;
  logic          flush = 1'b0;
  logic          out_ready = 1'b0;
  logic [AB-1:0] in_PC = '0;
  logic [31:0]   in_instr = '0;

  logic          in_ready, out_valid, wEn, mem_wEn, wb_sel, op_B_sel;
  logic          branch_op, jal_op, jalr_op, illegal;
  logic [AB-1:0] out_PC, jal_target;
  logic [4:0]    read_sel1, read_sel2, write_sel;
  logic [1:0]    op_A_sel;
  logic [5:0]    ALU_Control;
  logic [31:0]   imm32;
`ifdef DECODE_PERF_CNT_EN
  logic [31:0]   stall_cycles, issued_count;
`endif

  pipelined_decode #(.ADDRESS_BITS(AB), .LOAD_LAT(LL)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_PC(in_PC), .in_instr(in_instr), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .out_PC(out_PC), .read_sel1(read_sel1),
    .read_sel2(read_sel2), .write_sel(write_sel), .wEn(wEn), .mem_wEn(mem_wEn),
    .wb_sel(wb_sel), .op_A_sel(op_A_sel), .op_B_sel(op_B_sel),
    .ALU_Control(ALU_Control), .imm32(imm32), .branch_op(branch_op),
    .jal_op(jal_op), .jalr_op(jalr_op), .jal_target(jal_target),
    .illegal(illegal)
`ifdef DECODE_PERF_CNT_EN
    , .stall_cycles(stall_cycles), .issued_count(issued_count)
`endif
  );

  always #5 clock = ~clock;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [AB-1:0] pc, tgt;
    logic [4:0]    rs1, rs2, rd;
    logic          wen, mwen, wbs, opb, br, jal, jalr, ill, u1, u2, ld;
    logic [1:0]    opa;
    logic [5:0]    alu;
    logic [31:0]   imm;
  } ref_t;

  ref_t m;
  bit   mv;
  bit   m_zero;
  int   busy_until [32];
  int   cyc = 0;
  bit   last_ready;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Classes: 0 R, 1 I, 2 LOAD, 3 STORE, 4 BRANCH, 5 JAL, 6 JALR, 7 AUIPC, 8 LUI, 9 illegal
  function automatic ref_t ref_decode(input logic [31:0] ins, input logic [AB-1:0] pc);
    ref_t r;
    int cls;
    logic [2:0] f3;
    logic [31:0] b, j;
    r = '{default: '0};
    f3 = ins[14:12];
    case (ins[6:0])
      7'h33: cls = 0;
      7'h13: cls = 1;
      7'h03: cls = 2;
      7'h23: cls = 3;
      7'h63: cls = 4;
      7'h6F: cls = 5;
      7'h67: cls = 6;
      7'h17: cls = 7;
      7'h37: cls = 8;
      default: cls = 9;
    endcase
    r.pc   = pc;
    r.rs1  = ins[19:15];
    r.rs2  = ins[24:20];
    r.rd   = ins[11:7];
    r.wen  = (cls inside {0, 1, 2, 5, 6, 7, 8}) && (ins[11:7] != 5'd0);
    r.mwen = (cls == 3);
    r.wbs  = (cls == 2);
    r.ld   = (cls == 2);
    r.u1   = cls inside {0, 1, 2, 3, 4, 6};
    r.u2   = cls inside {0, 3, 4};
    r.br   = (cls == 4);
    r.jal  = (cls == 5);
    r.jalr = (cls == 6);
    r.ill  = (cls == 9);
    r.opa  = (cls inside {5, 6, 7}) ? 2'b01 : ((cls == 8) ? 2'b10 : 2'b00);
    r.opb  = (cls == 0) || (cls == 4);
    case (cls)
      0: r.alu = {1'b0, ins[30], 1'b0, f3};
      1: r.alu = (f3 == 3'd5) ? {1'b0, ins[30], 1'b0, f3} : {3'b000, f3};
      4: r.alu = 6'd32 + 6'(f3);
      default: r.alu = 6'd0;
    endcase
    b = 32'(ins[11:8]) * 2 + 32'(ins[30:25]) * 32 + 32'(ins[7]) * 2048;
    if (ins[31]) b = b | 32'hFFFF_F000;
    case (cls)
      1, 2: r.imm = 32'($signed(ins) >>> 20);
      3: r.imm = (32'($signed(ins) >>> 20) & 32'hFFFF_FFE0) | ((ins >> 7) & 32'h1F);
      4: r.imm = b;
      5, 6: r.imm = 32'd4;
      7, 8: r.imm = ins & 32'hFFFF_F000;
      default: r.imm = 32'd0;
    endcase
    j = 32'(ins[30:21]) * 2 + 32'(ins[20]) * 2048 + 32'(ins[19:12]) * 4096;
    if (ins[31]) j = j | 32'hFFF0_0000;
    r.tgt = AB'(32'(pc) + j);
    return r;
  endfunction

  function automatic bit busy(input logic [4:0] r);
    return (mv && m.ld && (m.rd == r)) || (busy_until[r] >= cyc);
  endfunction

  task automatic model_reset();
    mv = 1'b0;
    m_zero = 1'b1;
    m = '{default: '0};
    for (int i = 0; i < 32; i++) busy_until[i] = -1;
  endtask

  task automatic check_out();
    chk("out_valid", 32'(out_valid), 32'(mv));
    if (mv || m_zero) begin
      chk("out_PC", 32'(out_PC), 32'(m.pc));
      chk("read_sel1", 32'(read_sel1), 32'(m.rs1));
      chk("read_sel2", 32'(read_sel2), 32'(m.rs2));
      chk("write_sel", 32'(write_sel), 32'(m.rd));
      chk("wEn", 32'(wEn), 32'(m.wen));
      chk("mem_wEn", 32'(mem_wEn), 32'(m.mwen));
      chk("wb_sel", 32'(wb_sel), 32'(m.wbs));
      chk("op_A_sel", 32'(op_A_sel), 32'(m.opa));
      chk("op_B_sel", 32'(op_B_sel), 32'(m.opb));
      chk("ALU_Control", 32'(ALU_Control), 32'(m.alu));
      chk("imm32", imm32, m.imm);
      chk("branch_op", 32'(branch_op), 32'(m.br));
      chk("jal_op", 32'(jal_op), 32'(m.jal));
      chk("jalr_op", 32'(jalr_op), 32'(m.jalr));
      chk("illegal", 32'(illegal), 32'(m.ill));
      if (mv) chk("jal_target", 32'(jal_target), 32'(m.tgt));
    end
  endtask

  // One clock: check in_ready before the edge, advance model, check outputs after.
  task automatic step();
    ref_t d;
    bit haz, exp_ready;
    #2;
    d = ref_decode(in_instr, in_PC);
    haz = in_valid && ((d.u1 && (d.rs1 != 5'd0) && busy(d.rs1)) ||
                       (d.u2 && (d.rs2 != 5'd0) && busy(d.rs2)));
    if (!reset) exp_ready = 1'b0;
    else exp_ready = flush || ((!mv || out_ready) && !haz);
    chk("in_ready", 32'(in_ready), 32'(exp_ready));
    last_ready = in_ready;
    if (!reset) begin
      model_reset();
    end else begin
      if (mv && out_ready && m.ld && (m.rd != 5'd0)) busy_until[m.rd] = cyc + LL;
      if (flush) mv = 1'b0;
      else if (in_valid && exp_ready) begin
        mv = 1'b1;
        m = d;
        m_zero = 1'b0;
      end else if (mv && out_ready) mv = 1'b0;
    end
    cyc++;
    @(posedge clock);
    #1;
    check_out();
  endtask

  logic [6:0] ops [10] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h17, 7'h37, 7'h7F};

  initial begin
    int stalls, bubbles;
    bit done;
    logic [31:0] ins;

    model_reset();

    // Reset held with a valid instruction presented
    reset = 1'b0; in_valid = 1'b1; in_instr = 32'h002081B3; in_PC = 16'h0010; out_ready = 1'b1;
    step();
    step();
    chk("rst_in_ready", 32'(last_ready), 32'd0);

    // ADD x3,x1,x2
    reset = 1'b1;
    step();
    in_valid = 1'b0;
    chk("add_valid", 32'(out_valid), 32'd1);
    chk("add_alu", 32'(ALU_Control), 32'd0);
    chk("add_wen", 32'(wEn), 32'd1);
    chk("add_rd", 32'(write_sel), 32'd3);
    chk("add_opb", 32'(op_B_sel), 32'd1);

    // Load-use: LW x5 then ADD x6,x5,x5
    in_valid = 1'b1; in_instr = 32'h0000A283; in_PC = 16'h0014;
    step();
    in_instr = 32'h00528333; in_PC = 16'h0018;
    stalls = 0; bubbles = 0; done = 1'b0;
    for (int k = 0; k < 20 && !done; k++) begin
      step();
      if (!last_ready) stalls++;
      else in_valid = 1'b0;
      if (out_valid && (out_PC == 16'h0018)) done = 1'b1;
      else if (!out_valid) bubbles++;
    end
    in_valid = 1'b0;
    chk("lu_done", 32'(done), 32'd1);
    chk("lu_stalls", 32'(stalls), 32'd3);
    chk("lu_bubbles", 32'(bubbles), 32'd3);

    // JAL x1,+8
    in_valid = 1'b1; in_instr = 32'h008000EF; in_PC = 16'h0020;
    step();
    in_valid = 1'b0;
    chk("jal_op", 32'(jal_op), 32'd1);
    chk("jal_tgt", 32'(jal_target), 32'h0028);
    chk("jal_imm", imm32, 32'd4);
    chk("jal_opa", 32'(op_A_sel), 32'd1);
    chk("jal_wen", 32'(wEn), 32'd1);

    // BEQ x1,x2,-4
    in_valid = 1'b1; in_instr = 32'hFE208EE3; in_PC = 16'h0024;
    step();
    in_valid = 1'b0;
    chk("beq_br", 32'(branch_op), 32'd1);
    chk("beq_imm", imm32, 32'hFFFF_FFFC);
    chk("beq_alu", 32'(ALU_Control), 32'h20);
    chk("beq_wen", 32'(wEn), 32'd0);

    // Backpressure then flush
    in_valid = 1'b1; in_instr = 32'h00500393; in_PC = 16'h0040;
    step();
    in_valid = 1'b0; out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("hold_pc", 32'(out_PC), 32'h0040);
      chk("hold_ready", 32'(last_ready), 32'd0);
    end
    flush = 1'b1; in_valid = 1'b1; in_instr = 32'h002081B3; in_PC = 16'h0044;
    step();
    chk("flush_ready", 32'(last_ready), 32'd1);
    chk("flush_valid", 32'(out_valid), 32'd0);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("flush_drop", 32'(out_valid), 32'd0);
    end

    // Illegal opcode, then ADDI x0,x0,0
    in_valid = 1'b1; in_instr = 32'h0000007F; in_PC = 16'h0050;
    step();
    chk("ill_flag", 32'(illegal), 32'd1);
    chk("ill_wen", 32'(wEn), 32'd0);
    chk("ill_mwen", 32'(mem_wEn), 32'd0);
    chk("ill_valid", 32'(out_valid), 32'd1);
    in_instr = 32'h00000013; in_PC = 16'h0054;
    step();
    in_valid = 1'b0;
    chk("nop_wen", 32'(wEn), 32'd0);
    chk("nop_ill", 32'(illegal), 32'd0);

    // Randomized traffic over a small register set to provoke hazards
    for (int k = 0; k < 800; k++) begin
      ins = $urandom;
      ins[6:0]   = ops[$urandom_range(0, 9)];
      ins[11:7]  = 5'($urandom_range(0, 3));
      ins[19:15] = 5'($urandom_range(0, 3));
      ins[24:20] = 5'($urandom_range(0, 3));
      in_instr  = ins;
      in_PC     = AB'($urandom);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 24) == 0);
      reset     = ($urandom_range(0, 149) != 0);
      step();
    end
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
